dmem_lsu: RTL and testbench

//  Parametrised data memory with an integrated load/store unit, for the core's MEM stage.

---
 rtl/dmem_lsu.sv | 148 ++++++++++++++
 tb/tb_dmem_lsu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Data memory with an integrated load/store unit for the MEM stage.
// Takes byte addresses and RV32 funct3 codes, builds byte-lane masks,
// extends loads, flags faulty accesses, and answers after LATENCY cycles
// through a valid/ready request and a one-cycle response strobe.
module dmem_lsu #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pend_rdata_q, pend_rdata_d;
  logic            pend_err_q, pend_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            illegal, misal, oor, fault;
  logic [ADDR_W-1:0] word_addr;
  logic [IW-1:0]   idx;
  logic [31:0]     rd_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;
  logic [31:0]     acc_rdata;
  logic [3:0]      wmask;
  logic [31:0]     wword;

  assign accept = req_valid & req_ready;

  // Decode the request: fault priority only matters for reporting, any fault
  // suppresses the write and zeroes the data.
  always_comb begin
    word_addr = req_addr >> 2;
    idx       = req_addr[IW+1:2];
    illegal   = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11) ||
                (req_funct3[2] && req_we);
    misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oor       = word_addr >= ADDR_W'(DEPTH);
    fault     = illegal | misal | oor;
    rd_word   = mem[idx];
    ld_byte   = rd_word[8*req_addr[1:0] +: 8];
    ld_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_ext = rd_word;
      3'd4:    ld_ext = {24'b0, ld_byte};
      3'd5:    ld_ext = {16'b0, ld_half};
      default: ld_ext = 32'b0;
    endcase
    acc_rdata = (req_we || fault) ? 32'b0 : ld_ext;
    case (req_funct3[1:0])
      2'b00:   begin wmask = 4'b0001 << req_addr[1:0];       wword = {4{req_wdata[7:0]}};  end
      2'b01:   begin wmask = 4'b0011 << {req_addr[1], 1'b0}; wword = {2{req_wdata[15:0]}}; end
      default: begin wmask = 4'b1111;                        wword = req_wdata;            end
    endcase
  end

  // Stores commit at the accept edge; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  // FSM state register plus response/pending datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next state: WAIT holds LATENCY-1 cycles (none when LATENCY is 1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result capture: pending result latched at accept, published on RESP entry
  // so rsp_rdata keeps the previous response until the next one.
  always_comb begin
    pend_rdata_d = accept ? acc_rdata : pend_rdata_q;
    pend_err_d   = accept ? fault     : pend_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    if (state_d == RESP && state_q != RESP) begin
      rsp_rdata_d = pend_rdata_d;
      rsp_err_d   = pend_err_d;
    end
  end

  // FSM outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed table, multi-cycle corner
// sequences, then randomized traffic against a byte-array reference model.
module tb_dmem_lsu;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic        clk = 0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [7:0] mb [DEPTH*4];
  logic        have_prev;
  logic [31:0] prev_rd;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, access size from funct3.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int sz;
    logic [31:0] v;
    err = 0; rd = 0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (sz == 0 || (we && f3 >= 4)) err = 1;
    else if (addr % sz != 0)        err = 1;
    else if (addr / 4 >= DEPTH)     err = 1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mb[addr + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[addr + i]) << (8*i));
      if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 1);
      rd = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int n;
    bit seen;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    if (have_prev) chk("rdata_hold", rsp_rdata, prev_rd);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (rsp_valid) seen = 1;
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(LAT));
    rd = rsp_rdata; err = rsp_err;
    prev_rd = rd; have_prev = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic        err, eerr;
    bit          any;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;

    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    have_prev = 0; prev_rd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);

    tbl.push_back('{1, 3'd2, 32'h00,   32'h0,        32'h0,        0, "sw0"});
    tbl.push_back('{1, 3'd2, 32'h64,   32'h84755779, 32'h0,        0, "sw64"});
    tbl.push_back('{0, 3'd2, 32'h64,   32'h0,        32'h84755779, 0, "lw64"});
    tbl.push_back('{1, 3'd0, 32'h65,   32'h123456AA, 32'h0,        0, "sb65"});
    tbl.push_back('{0, 3'd0, 32'h65,   32'h0,        32'hFFFFFFAA, 0, "lb65"});
    tbl.push_back('{0, 3'd4, 32'h65,   32'h0,        32'h000000AA, 0, "lbu65"});
    tbl.push_back('{0, 3'd2, 32'h64,   32'h0,        32'h8475AA79, 0, "lw64b"});
    tbl.push_back('{1, 3'd1, 32'h66,   32'h00001234, 32'h0,        0, "sh66"});
    tbl.push_back('{0, 3'd1, 32'h66,   32'h0,        32'h00001234, 0, "lh66"});
    tbl.push_back('{1, 3'd1, 32'h66,   32'hFFFF8000, 32'h0,        0, "sh66b"});
    tbl.push_back('{0, 3'd1, 32'h66,   32'h0,        32'hFFFF8000, 0, "lh66b"});
    tbl.push_back('{0, 3'd5, 32'h66,   32'h0,        32'h00008000, 0, "lhu66"});
    tbl.push_back('{0, 3'd2, 32'h62,   32'h0,        32'h0,        1, "lw_misal"});
    tbl.push_back('{1, 3'd1, 32'h03,   32'hBEEF,     32'h0,        1, "sh_misal"});
    tbl.push_back('{0, 3'd2, DEPTH*4,  32'h0,        32'h0,        1, "lw_oor"});
    tbl.push_back('{1, 3'd2, DEPTH*4,  32'hDEADBEEF, 32'h0,        1, "sw_oor"});
    tbl.push_back('{1, 3'd4, 32'h64,   32'hFF,       32'h0,        1, "st_f3_4"});
    tbl.push_back('{0, 3'd3, 32'h64,   32'h0,        32'h0,        1, "ld_f3_3"});
    tbl.push_back('{1, 3'd7, 32'h64,   32'h0,        32'h0,        1, "st_f3_7"});
    tbl.push_back('{0, 3'd2, 32'h64,   32'h0,        32'h8000AA79, 0, "lw64_after"});
    tbl.push_back('{0, 3'd2, 32'h00,   32'h0,        32'h0,        0, "lw0_after"});

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, err);
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, eerr);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].exp_err));
    end

    // Back-to-back with req_valid held: next accept only in IDLE after RESP.
    @(negedge clk);
    req_we = 0; req_funct3 = 3'd2; req_addr = 32'h64; req_valid = 1;
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("b2b_ready_low", 32'(req_ready), 32'd0);
    end
    chk("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'h8000AA79);
    @(negedge clk);
    chk("b2b_ready_high", 32'(req_ready), 32'd1);
    chk("b2b_rsp_gap", 32'(rsp_valid), 32'd0);
    req_addr = 32'h00;
    @(posedge clk); #1; req_valid = 0;
    any = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT && rsp_valid) any = 1;
    end
    chk("b2b_rsp2_early", 32'(any), 32'd0);
    chk("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h0);
    have_prev = 0;

    // Reset while waiting: response dropped, store already committed.
    @(negedge clk);
    req_we = 1; req_funct3 = 3'd2; req_addr = 32'h70; req_wdata = 32'h5A5A1234; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    model(1, 3'd2, 32'h70, 32'h5A5A1234, erd, eerr);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_rdata", rsp_rdata, 32'd0);
    any = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      if (rsp_valid) any = 1;
      @(negedge clk);
    end
    chk("rstw_no_rsp", 32'(any), 32'd0);
    do_req(0, 3'd2, 32'h70, 0, rd, err);
    chk("rstw_readback", rd, 32'h5A5A1234);

    // Randomized traffic over words 16..31 plus occasional faults.
    for (int w = 16; w < 32; w++) begin
      wd = $urandom;
      do_req(1, 3'd2, 32'(w*4), wd, rd, err);
      model(1, 3'd2, 32'(w*4), wd, erd, eerr);
    end
    for (int t = 0; t < 250; t++) begin
      we = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       f3 = 3'($urandom);
        1, 2:    f3 = 3'd0;
        3, 4:    f3 = 3'd1;
        5, 6:    f3 = 3'd2;
        7:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      case ($urandom_range(0, 11))
        0:       addr = 32'(DEPTH*4) + 32'($urandom_range(0, 255));
        1:       addr = $urandom | 32'h8000_0000;
        default: addr = 32'($urandom_range(64, 127));
      endcase
      wd = $urandom;
      do_req(we, f3, addr, wd, rd, err);
      model(we, f3, addr, wd, erd, eerr);
      chk($sformatf("rnd%0d_rdata", t), rd, erd);
      chk($sformatf("rnd%0d_err", t), 32'(err), 32'(eerr));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
